rs_br_alloc_issue: RTL and testbench

- Allocation and issue controller for the branch reservation station. Sits between dispatch and the branch entries, and between the entries and the branch execution unit.
- Each cycle it picks up to two free entries for incoming dispatched branches and drives the entry write-enables.
- It tracks relative age in an age matrix and issues the oldest ready entry by driving its read-enable to the branch execution unit.

---
 rtl/rs_br_alloc_issue_pkg.sv | 10 +
 rtl/constants.vh | 6 +
 rtl/rs_br_alloc_issue_age_matrix.sv | 78 +++++++
 rtl/rs_br_alloc_issue.sv | 98 +++++++++
 tb/tb_rs_br_alloc_issue.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/rs_br_alloc_issue_pkg.sv
// rtl/rs_br_alloc_issue_pkg.sv - sizing constants for the branch RS alloc/issue slice
`include "constants.vh"

package rs_br_alloc_issue_pkg;

  // Default entry count and index width of the branch reservation station.
  localparam int RS_ENT_NUM = `RS_BR_ENT_NUM;
  localparam int RS_ENT_SEL = `RS_BR_ENT_SEL;

endpackage

// File: rtl/constants.vh
// rtl/constants.vh - shared sizing constants for the branch reservation station
`ifndef RS_BR_CONSTANTS_VH
`define RS_BR_CONSTANTS_VH
`define RS_BR_ENT_NUM 8
`define RS_BR_ENT_SEL 3
`endif

// File: rtl/rs_br_alloc_issue_age_matrix.sv
// rtl/rs_br_alloc_issue_age_matrix.sv - relative-age matrix and oldest-ready pick
module rs_age_matrix
  import rs_br_alloc_issue_pkg::*;
#(
  parameter int ENT_NUM = RS_ENT_NUM,
  parameter int ENT_SEL = RS_ENT_SEL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [ENT_NUM-1:0] busy_vec_i,
  input  logic               alloc0_en_i,
  input  logic [ENT_SEL-1:0] alloc0_sel_i,
  input  logic               alloc1_en_i,
  input  logic [ENT_SEL-1:0] alloc1_sel_i,
  input  logic               issue_en_i,
  input  logic [ENT_SEL-1:0] issue_sel_i,
  input  logic [ENT_NUM-1:0] vld_vec_i,
  output logic [ENT_NUM-1:0] oldest_o
);

  // old_q[i][j] = 1 means entry i is older than entry j.
  logic [ENT_NUM-1:0] old_q [ENT_NUM];
  logic [ENT_NUM-1:0] old_d [ENT_NUM];
  logic [ENT_NUM-1:0] elig;
  logic [ENT_NUM-1:0] cand;
  logic [ENT_NUM-1:0] col;
  logic               found;

  // Next matrix: issue clears row/col; allocation makes every occupied entry older.
  always_comb begin
    for (int i = 0; i < ENT_NUM; i++) old_d[i] = old_q[i];
    if (rst || flush_i) begin
      for (int i = 0; i < ENT_NUM; i++) old_d[i] = '0;
    end else begin
      if (issue_en_i) begin
        old_d[issue_sel_i] = '0;
        for (int j = 0; j < ENT_NUM; j++) old_d[j][issue_sel_i] = 1'b0;
      end
      if (alloc0_en_i) begin
        old_d[alloc0_sel_i] = '0;
        for (int j = 0; j < ENT_NUM; j++) old_d[j][alloc0_sel_i] = busy_vec_i[j];
      end
      if (alloc1_en_i) begin
        old_d[alloc1_sel_i] = '0;
        for (int j = 0; j < ENT_NUM; j++) old_d[j][alloc1_sel_i] = busy_vec_i[j];
        // Slot 0 is program-order older than slot 1 of the same dispatch group.
        if (alloc0_en_i) old_d[alloc0_sel_i][alloc1_sel_i] = 1'b1;
      end
    end
  end

  // Matrix register; reset and flush are folded into old_d.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENT_NUM; i++) old_q[i] <= old_d[i];
  end

  // Oldest ready entry; lowest index wins if the matrix ever yields a tie or a cycle.
  always_comb begin
    elig     = '0;
    cand     = '0;
    col      = '0;
    oldest_o = '0;
    found    = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      for (int j = 0; j < ENT_NUM; j++) col[j] = old_q[j][i];
      elig[i] = vld_vec_i[i] & ~|(vld_vec_i & col);
    end
    cand = (|elig) ? elig : vld_vec_i;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (cand[i] && !found) begin
        oldest_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_br_alloc_issue.sv
// rtl/rs_br_alloc_issue.sv - branch RS allocation and oldest-ready issue controller
module rs_br_alloc_issue
  import rs_br_alloc_issue_pkg::*;
#(
  parameter int ENT_NUM = RS_ENT_NUM,
  parameter int ENT_SEL = RS_ENT_SEL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENT_NUM-1:0] i_busy_vec,
  input  logic [ENT_NUM-1:0] i_vld_vec,
  input  logic [1:0]         i_dp_req,
  output logic               o_alloc_rdy,
  output logic [ENT_NUM-1:0] o_wr_en,
  output logic [ENT_SEL-1:0] o_wr_sel_0,
  output logic [ENT_SEL-1:0] o_wr_sel_1,
  input  logic               i_ex_rdy,
  output logic [ENT_NUM-1:0] o_rd_en,
  output logic               o_issue_vld,
  output logic [ENT_SEL-1:0] o_issue_sel,
  input  logic               i_flush
);

  logic [ENT_NUM-1:0] free_vec;
  logic [ENT_SEL-1:0] sel0;
  logic [ENT_SEL-1:0] sel1;
  logic               found0;
  logic               found1;
  logic               alloc_fire;
  logic               alloc0_en;
  logic               alloc1_en;
  logic [ENT_NUM-1:0] oldest;
  logic [ENT_SEL-1:0] oldest_sel;

  assign free_vec = ~i_busy_vec;

  // Two lowest-index free entries for dispatch slots 0 and 1.
  always_comb begin
    sel0   = '0;
    sel1   = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (free_vec[i]) begin
        if (!found0) begin
          sel0   = ENT_SEL'(i);
          found0 = 1'b1;
        end else if (!found1) begin
          sel1   = ENT_SEL'(i);
          found1 = 1'b1;
        end
      end
    end
  end

  // All-or-nothing allocation; nothing is written during reset or flush.
  always_comb begin
    o_alloc_rdy = ~rst & ($countones(free_vec) >= $countones(i_dp_req));
    alloc_fire  = o_alloc_rdy & ~i_flush;
    alloc0_en   = alloc_fire & i_dp_req[0];
    alloc1_en   = alloc_fire & i_dp_req[1];
    o_wr_en     = '0;
    if (alloc0_en) o_wr_en[sel0] = 1'b1;
    if (alloc1_en) o_wr_en[sel1] = 1'b1;
    o_wr_sel_0  = rst ? '0 : sel0;
    o_wr_sel_1  = rst ? '0 : sel1;
  end

  // Encode the oldest-ready one-hot and gate issue with execution-unit readiness.
  always_comb begin
    oldest_sel = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (oldest[i]) oldest_sel = ENT_SEL'(i);
    end
    o_issue_vld = (|oldest) & i_ex_rdy & ~i_flush & ~rst;
    o_rd_en     = o_issue_vld ? oldest : '0;
    o_issue_sel = o_issue_vld ? oldest_sel : '0;
  end

  rs_age_matrix #(
    .ENT_NUM (ENT_NUM),
    .ENT_SEL (ENT_SEL)
  ) u_age (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (i_flush),
    .busy_vec_i   (i_busy_vec),
    .alloc0_en_i  (alloc0_en),
    .alloc0_sel_i (sel0),
    .alloc1_en_i  (alloc1_en),
    .alloc1_sel_i (sel1),
    .issue_en_i   (o_issue_vld),
    .issue_sel_i  (o_issue_sel),
    .vld_vec_i    (i_vld_vec),
    .oldest_o     (oldest)
  );

endmodule

// File: tb/tb_rs_br_alloc_issue.sv
// tb/tb_rs_br_alloc_issue.sv - directed self-checking bench for rs_br_alloc_issue
module tb_rs_br_alloc_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] busy;
  logic [7:0] vld;
  logic [1:0] req;
  logic       ex_rdy;
  logic       flush;
  logic       alloc_rdy;
  logic [7:0] wr_en;
  logic [2:0] wr_sel_0;
  logic [2:0] wr_sel_1;
  logic [7:0] rd_en;
  logic       issue_vld;
  logic [2:0] issue_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_br_alloc_issue dut (
    .clk         (clk),
    .rst         (rst),
    .i_busy_vec  (busy),
    .i_vld_vec   (vld),
    .i_dp_req    (req),
    .o_alloc_rdy (alloc_rdy),
    .o_wr_en     (wr_en),
    .o_wr_sel_0  (wr_sel_0),
    .o_wr_sel_1  (wr_sel_1),
    .i_ex_rdy    (ex_rdy),
    .o_rd_en     (rd_en),
    .o_issue_vld (issue_vld),
    .o_issue_sel (issue_sel),
    .i_flush     (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move just past a rising edge, apply inputs, let combinational outputs settle.
  task automatic step(input logic r, input logic [7:0] b, input logic [7:0] v,
                      input logic [1:0] q, input logic e, input logic f);
    @(posedge clk);
    #1;
    rst = r; busy = b; vld = v; req = q; ex_rdy = e; flush = f;
    #1;
  endtask

  initial begin
    rst = 1'b1; busy = '0; vld = '0; req = '0; ex_rdy = 1'b0; flush = 1'b0;

    step(1, 8'h00, 8'hFF, 2'b11, 1, 0);
    step(1, 8'h00, 8'hFF, 2'b11, 1, 0);
    chk("rst_alloc_rdy", alloc_rdy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_issue_vld", issue_vld, 0);
    chk("rst_wr_sel_1", wr_sel_1, 0);

    step(0, 8'h00, 8'h00, 2'b11, 0, 0);
    chk("free_alloc_rdy", alloc_rdy, 1);
    chk("free_wr_en", wr_en, 8'h03);
    chk("free_sel0", wr_sel_0, 0);
    chk("free_sel1", wr_sel_1, 1);
    chk("free_issue_vld", issue_vld, 0);

    step(0, 8'hFE, 8'h00, 2'b11, 0, 0);
    chk("one_free_pair_rdy", alloc_rdy, 0);
    chk("one_free_pair_wr", wr_en, 0);
    step(0, 8'hFE, 8'h00, 2'b01, 0, 0);
    chk("one_free_single_rdy", alloc_rdy, 1);
    chk("one_free_single_wr", wr_en, 8'h01);
    step(0, 8'hFF, 8'h00, 2'b01, 0, 0);
    chk("full_rdy", alloc_rdy, 0);
    chk("full_wr", wr_en, 0);
    step(0, 8'hFF, 8'h00, 2'b00, 0, 0);
    chk("full_noreq_rdy", alloc_rdy, 1);

    // Matrix now says entry 1 is older than 0; flush must wipe that.
    step(0, 8'hFF, 8'h03, 2'b01, 1, 1);
    chk("flush_wr_en", wr_en, 0);
    chk("flush_rd_en", rd_en, 0);
    chk("flush_issue_vld", issue_vld, 0);
    step(0, 8'h03, 8'h03, 2'b00, 1, 0);
    chk("post_flush_rd_en", rd_en, 8'h01);
    chk("post_flush_sel", issue_sel, 0);
    step(0, 8'h00, 8'h00, 2'b01, 0, 0);
    chk("new_alloc_wr", wr_en, 8'h01);
    step(0, 8'h01, 8'h01, 2'b00, 1, 0);
    chk("new_alloc_issue", rd_en, 8'h01);

    step(0, 8'hDF, 8'h00, 2'b01, 0, 0);
    chk("alloc5_wr", wr_en, 8'h20);
    chk("alloc5_sel", wr_sel_0, 5);
    step(0, 8'hFB, 8'h00, 2'b01, 0, 0);
    chk("alloc2_wr", wr_en, 8'h04);
    step(0, 8'hFF, 8'h24, 2'b00, 1, 0);
    chk("age_first_rd_en", rd_en, 8'h20);
    chk("age_first_sel", issue_sel, 5);
    chk("age_first_vld", issue_vld, 1);
    step(0, 8'hDF, 8'h04, 2'b00, 1, 0);
    chk("age_second_sel", issue_sel, 2);
    chk("age_second_rd_en", rd_en, 8'h04);

    step(0, 8'hFC, 8'h00, 2'b11, 0, 0);
    chk("pair01_wr", wr_en, 8'h03);
    step(0, 8'hFF, 8'h02, 2'b00, 0, 0);
    chk("exrdy0_issue_vld", issue_vld, 0);
    chk("exrdy0_rd_en", rd_en, 0);
    step(0, 8'hFF, 8'h02, 2'b00, 1, 0);
    chk("exrdy1_rd_en", rd_en, 8'h02);
    chk("exrdy1_sel", issue_sel, 1);
    step(0, 8'hFD, 8'h01, 2'b00, 1, 0);
    chk("entry0_rd_en", rd_en, 8'h01);

    step(0, 8'h0F, 8'h08, 2'b00, 1, 0);
    chk("issue3_rd_en", rd_en, 8'h08);
    step(0, 8'h07, 8'h00, 2'b01, 0, 0);
    chk("realloc3_sel", wr_sel_0, 3);
    chk("realloc3_wr", wr_en, 8'h08);

    // Entry 3 older than a fresh pair 0,1; slot 0 older than slot 1.
    step(0, 8'h08, 8'h00, 2'b11, 0, 0);
    chk("pair_after3_wr", wr_en, 8'h03);
    step(0, 8'h0B, 8'h0B, 2'b00, 1, 0);
    chk("oldest3_rd_en", rd_en, 8'h08);
    step(0, 8'h03, 8'h03, 2'b00, 1, 0);
    chk("slot0_first_rd_en", rd_en, 8'h01);
    step(0, 8'h02, 8'h02, 2'b00, 1, 0);
    chk("slot1_last_rd_en", rd_en, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
